// File: rtl/ram_pkg.sv
// ----------------------------------------------------------------------------
// ram_pkg
// Shared definitions for the RAM controller slice:
//   - default parameter values for ram_ctrl / ram_array
//   - FSM state encodings (ST_INIT, ST_IDLE)
//   - helper for sizing the clear counter
// No ports (package).
// ----------------------------------------------------------------------------
package ram_pkg;

    localparam int unsigned RAM_DATA_W         = 4;
    localparam int unsigned RAM_ADDR_W         = 12;
    localparam int unsigned RAM_DEPTH          = 4096;
    localparam bit          RAM_CLEAR_ON_RESET = 1'b1;

    localparam logic [0:0] ST_INIT = 1'b0;  // sweeping zeros through memory
    localparam logic [0:0] ST_IDLE = 1'b1;  // serving requests

    // Clear counter must be able to hold DEPTH itself, not just DEPTH-1.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ram_array.sv
// ----------------------------------------------------------------------------
// ram_array
// Single-port storage, DEPTH x DATA_W, synchronous write, registered read,
// no reset. The read register only updates on i_re, so o_rdata holds the
// last word read between reads.
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_re     in   read enable
//   i_addr   in   word address (caller guarantees i_addr < DEPTH when enabled)
//   i_wdata  in   write data
//   o_rdata  out  registered read data
// ----------------------------------------------------------------------------
module ram_array
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = RAM_DATA_W,
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DEPTH  = RAM_DEPTH
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_ctrl.sv
// ----------------------------------------------------------------------------
// ram_ctrl
// Request front-end for ram_array: optional zero-fill after reset (INIT),
// request acceptance gated by ready, range checking, latency-1 read return.
// Ports:
//   clk       in   clock, all state changes on rising edge
//   rst_n     in   synchronous active-low reset
//   cs        in   request strobe
//   we        in   1 = write, 0 = read (sampled with cs)
//   addr      in   word address
//   wdata     in   write data
//   rdata     out  read data (holds last value while rvalid=0)
//   rvalid    out  rdata valid this cycle
//   drive_en  out  external bus driver enable (== rvalid)
//   ready     out  requests accepted this cycle
//   err       out  out-of-range access flag, cycle after acceptance
// ----------------------------------------------------------------------------
module ram_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W         = RAM_DATA_W,
    parameter int unsigned ADDR_W         = RAM_ADDR_W,
    parameter int unsigned DEPTH          = RAM_DEPTH,
    parameter bit          CLEAR_ON_RESET = RAM_CLEAR_ON_RESET
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              drive_en,
    output logic              ready,
    output logic              err
);

    localparam int unsigned      CNT_W = cnt_width(DEPTH);
    localparam logic [ADDR_W:0]  LIMIT = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEPTH - 1);

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_clr_cnt;
    logic              r_ready;
    logic              r_rvalid;
    logic              r_rd_oor;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata_hold;

    logic              w_in_range;
    logic              w_accept;
    logic              w_clearing;
    logic              w_arr_we;
    logic              w_arr_re;
    logic [ADDR_W-1:0] w_arr_addr;
    logic [DATA_W-1:0] w_arr_wdata;
    logic [DATA_W-1:0] w_arr_rdata;
    logic [DATA_W-1:0] w_rdata;

    // Extra top bit so DEPTH == 2**ADDR_W compares correctly.
    assign w_in_range = {1'b0, addr} < LIMIT;

    // rst_n gating keeps requests and clear writes off the array during reset,
    // so reset itself never touches memory contents.
    assign w_accept   = rst_n & r_ready & cs;
    assign w_clearing = rst_n & (r_state == ST_INIT);

    // ready is low throughout INIT, so clear and request never collide.
    assign w_arr_we    = w_clearing | (w_accept & we & w_in_range);
    assign w_arr_re    = w_accept & ~we & w_in_range;
    assign w_arr_addr  = w_clearing ? ADDR_W'(r_clr_cnt) : addr;
    assign w_arr_wdata = w_clearing ? '0 : wdata;

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_re    (w_arr_re),
        .i_addr  (w_arr_addr),
        .i_wdata (w_arr_wdata),
        .o_rdata (w_arr_rdata)
    );

    // The array output register supplies latency-1 data; an out-of-range read
    // substitutes zero, and a separate hold register keeps rdata stable (and
    // resettable to zero) while no read is returning.
    assign w_rdata = r_rvalid ? (r_rd_oor ? '0 : w_arr_rdata) : r_rdata_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
            r_clr_cnt    <= '0;
            r_ready      <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rd_oor     <= 1'b0;
            r_err        <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            r_rvalid <= w_accept & ~we;
            r_rd_oor <= w_accept & ~we & ~w_in_range;
            r_err    <= w_accept & ~w_in_range;
            if (r_rvalid) begin
                r_rdata_hold <= w_rdata;
            end
            case (r_state)
                ST_INIT: begin
                    if (r_clr_cnt == LAST) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                end
                default: begin
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign rdata    = w_rdata;
    assign rvalid   = r_rvalid;
    assign drive_en = r_rvalid;
    assign ready    = r_ready;
    assign err      = r_err;

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DATA_W, 4, data word width in bits
- ADDR_W, 12, address width in bits
- DEPTH, 4096, number of words implemented (DEPTH ≤ 2**ADDR_W)
- CLEAR_ON_RESET, 1, when 1, memory is zeroed after reset
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on its rising edge
- rst_n, in, 1, reset; synchronous, active-low
- cs, in, 1, request strobe (chip select)
- we, in, 1, 1 = write, 0 = read; sampled with cs
- addr, in, ADDR_W, word address
- wdata, in, DATA_W, write data
- rdata, out, DATA_W, read data
- rvalid, out, 1, rdata valid for this cycle
- drive_en, out, 1, external bus driver enable; replaces internal tristate
- ready, out, 1, block accepts requests this cycle
- err, out, 1, out-of-range access flag

Function
REQ-003 The FSM SHALL have states INIT (memory clear) and IDLE (serving requests).
REQ-004 After reset release the FSM SHALL enter INIT if CLEAR_ON_RESET=1; otherwise it SHALL enter IDLE.
REQ-005 In INIT, a clear counter SHALL write 0 to addresses 0 to DEPTH-1, one per cycle, then go to IDLE on the cycle after address DEPTH-1 is written.
REQ-006 ready SHALL be 0 in INIT and 1 in IDLE.
REQ-007 A request SHALL be accepted only on an edge where cs=1 and ready=1; cs while ready=0 SHALL be dropped, with no queueing.
REQ-008 An accepted write SHALL update mem[addr] with wdata at the accepting edge and SHALL NOT assert rvalid.
REQ-009 An accepted read SHALL present mem[addr] on rdata, with rvalid=1 and drive_en=1, for exactly the cycle after acceptance (latency 1).
REQ-010 Reads SHALL be fully pipelined: a read accepted every cycle yields rvalid every cycle, in order.
REQ-011 A read following a write to the same address on the next edge SHALL return the new data.
REQ-012 rdata SHALL hold its last value while rvalid=0, and drive_en SHALL equal rvalid.
REQ-013 An access with addr ≥ DEPTH SHALL:
- leave memory unchanged;
- for a read, return rdata=0 with rvalid=1;
- pulse err=1 for the cycle after acceptance, for both reads and writes.
REQ-014 Address arithmetic SHALL be unsigned ADDR_W bits, and the clear counter SHALL be wide enough to reach DEPTH without wrap.

Reset
REQ-015 While rst_n=0 at a rising edge, the block SHALL set rdata=0, rvalid=0, drive_en=0, err=0, ready=0, and clear counter=0.
REQ-016 Reset asserted mid-INIT SHALL restart the clear from address 0.
REQ-017 Reset asserted with a read in flight SHALL suppress that read's rvalid.
REQ-018 Reset SHALL NOT clear memory contents directly; only INIT does.

Structure
REQ-019 The parameter defaults and state encodings (ST_INIT, ST_IDLE) SHALL live in the shared package/include ram_pkg.
REQ-020 The storage SHALL be a sub-module ram_array: single-port, synchronous write, registered read, DEPTH×DATA_W, with no reset.
REQ-021 The FSM, clear counter, range check and output registers SHALL reside in ram_ctrl.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (defaults unless stated):
- Reset release: ready=0 for 4096 cycles then 1; read 0x0FF → rdata=0x0, rvalid after 1 cycle.
- Write 0xA @0x123, then read 0x123 on the next edge → rdata=0xA, rvalid=1, drive_en=1 for one cycle.
- Reads @0x001, 0x002, 0x003 on consecutive edges (contents 0x1, 0x2, 0x3) → rvalid high 3 consecutive cycles with 0x1, 0x2, 0x3.
- DEPTH=3000: write 0x5 @3000 → err pulse, no change; read @3000 → rdata=0, err=1; read @2999 → err=0.
- rst_n low at INIT cycle 100, released → full 4096-cycle INIT again; cs=1 during INIT → no write, no rvalid.
- CLEAR_ON_RESET=0: ready=1 on the first cycle after reset; a read issued during reset → no rvalid.
